rv_instr_encoder: RTL

- Writer side of the instruction-field interface: accepts decoded-form instruction descriptors (format, opcode, funct3/funct7, rd/rs1/rs2, immediate) over a valid/ready handshake.
- Range-checks the immediate, packs the fields into an RV32I machine word (R/I/S/B/U/J), and writes it sequentially into instruction memory.
- Used by the bench and boot loader to fill instruction memory that the fetch/ID path later decodes.

---
 rtl/rv_instr_encoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rv_instr_encoder.sv
// Purpose: range-check decoded RV32I descriptors, pack them into machine words and write them sequentially into imem.
// Latency: accept at edge N, imem_we high during cycle N+1, in_ready high again in cycle N+2.
// Backpressure: in_ready low while a word is being written, while full, and while clr is asserted; one word per 2 cycles.
module rv_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_FMT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              legal;
    logic [1:0]        chk_code;
    logic [31:0]       enc_word;
    logic [ADDR_W:0]   count_inc;
    logic signed [31:0] imm_s;

    assign imm_s     = $signed(in_imm);
    assign count_inc = count + CNT_ONE;
    assign imem_addr = count[ADDR_W-1:0];
    assign full      = (count == DEPTH_CNT);

    // Immediate legality: format first, then signed range, then alignment.
    always_comb begin
        chk_code = ERR_NONE;
        case (in_fmt)
            FMT_R: chk_code = ERR_NONE;
            FMT_I, FMT_S: begin
                if (imm_s < -32'sd2048 || imm_s > 32'sd2047)
                    chk_code = ERR_RANGE;
            end
            FMT_B: begin
                if (imm_s < -32'sd4096 || imm_s > 32'sd4094)
                    chk_code = ERR_RANGE;
                else if (in_imm[0])
                    chk_code = ERR_ALIGN;
            end
            FMT_U: begin
                if (in_imm[11:0] != 12'd0)
                    chk_code = ERR_ALIGN;
            end
            FMT_J: begin
                if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574)
                    chk_code = ERR_RANGE;
                else if (in_imm[0])
                    chk_code = ERR_ALIGN;
            end
            default: chk_code = ERR_FMT;
        endcase
        legal = (chk_code == ERR_NONE);
    end

    // Field packing for each instruction format.
    always_comb begin
        enc_word = 32'd0;
        case (in_fmt)
            FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, in_opcode};
            default: enc_word = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake/strobe outputs; clr overrides everything.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Hiding ready during clr keeps the handshake honest: nothing is taken that cycle.
                in_ready = !clr;
                if (in_valid && !clr) begin
                    accept = 1'b1;
                    if (legal)
                        state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                imem_we   = 1'b1;
                state_nxt = (count_inc == DEPTH_CNT) ? ST_FULL : ST_IDLE;
            end
            ST_FULL: begin
                state_nxt = ST_FULL;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (clr)
            state_nxt = ST_IDLE;
    end

    // Datapath: captured word, write count and sticky error reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_wdata <= 32'd0;
            count      <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else if (clr) begin
            // A strobe issued this cycle still goes out but is deliberately not counted.
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (accept && legal)
                imem_wdata <= enc_word;
            if (accept && !legal) begin
                err      <= 1'b1;
                err_code <= chk_code;
            end
            if (state == ST_WRITE)
                count <= count_inc;
        end
    end

endmodule
